// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg - shared types and constants for the data-memory arbiter.
//   WIDTH_*      : encodings of the data_mem WidthSrc field
//   arb_state_t  : who owned the memory in the previous cycle
//   mem_req_t    : one port's access (we, width, addr, wdata)
package dmem_arb_pkg;

    localparam logic [1:0] WIDTH_WORD = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b10;
    localparam logic [1:0] WIDTH_BYTE = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        LOCK1 = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_if.sv
// dmem_arb_if - bundle of both requester ports and the data_mem side.
//   slave  : the arbiter (takes requests + mem_rdata, drives grants,
//            responses and the mem_* command)
//   master : the environment (requesters and data_mem model)
interface dmem_arb_if;
    logic        req0, req1;
    logic        we0, we1;
    logic [1:0]  width0, width1;
    logic [31:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        lock1;
    logic        gnt0, gnt1;
    logic        rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        err0, err1;
    logic        mem_we;
    logic [1:0]  mem_width;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, width0, width1, addr0, addr1,
               wdata0, wdata1, lock1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               mem_we, mem_width, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, width0, width1, addr0, addr1,
               wdata0, wdata1, lock1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
               mem_we, mem_width, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arb_align.sv
// dmem_arb_align - combinational misalignment detector for one port.
// Only instantiated when DMEM_ARB_ALIGN_CHECK_EN is defined.
//   width      in  2 : access width (11 behaves as word)
//   addr_lo    in  2 : low two address bits
//   misaligned out 1 : word not on a 4-byte boundary or odd halfword
module dmem_arb_align
    import dmem_arb_pkg::*;
(
    input  logic [1:0] width,
    input  logic [1:0] addr_lo,
    output logic       misaligned
);

    always_comb begin
        misaligned = 1'b0;
        if (width == WIDTH_HALF) begin
            misaligned = addr_lo[0];
        end else if (width != WIDTH_BYTE) begin
            // WIDTH_WORD and the unused 11 encoding both need word alignment
            misaligned = |addr_lo;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter - shares the single-ported data_mem between the pipeline
// load/store path (port 0) and a debug/DMA port (port 1).
//   clk      in : rising-edge clock
//   reset_n  in : asynchronous active-low reset
//   bus         : dmem_arb_if.slave (requests, grants, responses, mem_*)
// Port 0 has fixed priority; port 1 is protected by a starvation counter
// (MAX_WAIT) and may hold the memory in a burst lock bounded by MAX_LOCK.
// Optional build macro DMEM_ARB_ALIGN_CHECK_EN: misaligned accesses are
// granted but never written, and answer with err=1, rdata=0.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int MAX_LOCK = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    dmem_arb_if.slave   bus
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int LW = $clog2(MAX_LOCK + 1);

    arb_state_t  state_q, state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic        rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic        gnt0, gnt1;
    logic        bad0, bad1, win_bad;
    mem_req_t    req0_s, req1_s, win_s;

    assign req0_s = '{we: bus.we0, width: bus.width0, addr: bus.addr0, wdata: bus.wdata0};
    assign req1_s = '{we: bus.we1, width: bus.width1, addr: bus.addr1, wdata: bus.wdata1};

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    dmem_arb_align u_align0 (.width(bus.width0), .addr_lo(bus.addr0[1:0]), .misaligned(bad0));
    dmem_arb_align u_align1 (.width(bus.width1), .addr_lo(bus.addr1[1:0]), .misaligned(bad1));
`else
    assign bad0 = 1'b0;
    assign bad1 = 1'b0;
`endif

    // Arbitration: grants are combinational and suppressed while in reset,
    // which also forces every mem_* output (including mem_we) to 0.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset_n) begin
            gnt0 = 1'b0;
        end else if (state_q == LOCK1 && bus.req1) begin
            // a saturated lock yields exactly one slot to a waiting port 0
            if (bus.req0 && lock_cnt_q == LW'(MAX_LOCK)) gnt0 = 1'b1;
            else                                         gnt1 = 1'b1;
        end else if (bus.req1 && wait_cnt_q == WW'(MAX_WAIT)) begin
            gnt1 = 1'b1;
        end else if (bus.req0) begin
            gnt0 = 1'b1;
        end else if (bus.req1) begin
            gnt1 = 1'b1;
        end
    end

    // Next state and counters
    always_comb begin
        state_d    = IDLE;
        wait_cnt_d = wait_cnt_q;
        lock_cnt_d = lock_cnt_q;

        if (gnt0) begin
            // the yielded slot keeps the burst alive if port 1 still wants it
            state_d = (state_q == LOCK1 && bus.req1 && bus.lock1) ? LOCK1 : OWN0;
        end else if (gnt1) begin
            state_d = bus.lock1 ? LOCK1 : OWN1;
        end

        if (!bus.req1 || gnt1)               wait_cnt_d = '0;
        else if (wait_cnt_q != WW'(MAX_WAIT)) wait_cnt_d = wait_cnt_q + WW'(1);

        if (gnt0 || !bus.lock1)                        lock_cnt_d = '0;
        else if (gnt1 && lock_cnt_q != LW'(MAX_LOCK))  lock_cnt_d = lock_cnt_q + LW'(1);
    end

    // Memory command mux
    always_comb begin
        win_s   = '0;
        win_bad = 1'b0;
        if (gnt0) begin
            win_s   = req0_s;
            win_bad = bad0;
        end else if (gnt1) begin
            win_s   = req1_s;
            win_bad = bad1;
        end
    end

    assign bus.mem_we    = win_s.we & ~win_bad;
    assign bus.mem_width = win_s.width;
    assign bus.mem_addr  = win_s.addr;
    assign bus.mem_wdata = win_s.wdata;

    // Response capture: stores and rejected accesses return zero data
    always_comb begin
        rvalid0_d = gnt0;
        rvalid1_d = gnt1;
        err0_d    = gnt0 & bad0;
        err1_d    = gnt1 & bad1;
        rdata0_d  = '0;
        rdata1_d  = '0;
        if (gnt0 && !bus.we0 && !bad0) rdata0_d = bus.mem_rdata;
        if (gnt1 && !bus.we1 && !bad1) rdata1_d = bus.mem_rdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            lock_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign bus.err0    = err0_q;
    assign bus.err1    = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter - bench for dmem_arbiter with a byte-addressed data_mem
// model (256 bytes, little-endian) and an arbitration reference model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int MAX_WAIT = 4;
    localparam int MAX_LOCK = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    dmem_arb_if bus ();

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endfunction

    function automatic int nbytes(input logic [1:0] w);
        if (w == 2'b01) return 1;
        if (w == 2'b10) return 2;
        return 4;
    endfunction

    function automatic bit misal(input logic [1:0] w, input logic [31:0] a);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        if (w == 2'b01) return 1'b0;
        if (w == 2'b10) return a[0];
        return a[1:0] != 2'b00;
`else
        return (w == 2'b11) && (a == 32'hFFFF_FFFF);
`endif
    endfunction

    // ---------------- data_mem environment model ----------------
    logic [7:0] env_mem [256];

    always_comb begin
        bus.mem_rdata = '0;
        for (int i = 0; i < 4; i++)
            if (i < nbytes(bus.mem_width))
                bus.mem_rdata[8*i +: 8] = env_mem[8'(bus.mem_addr[7:0] + 8'(i))];
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= 8'h00;
        end else if (bus.mem_we) begin
            for (int i = 0; i < 4; i++)
                if (i < nbytes(bus.mem_width))
                    env_mem[8'(bus.mem_addr[7:0] + 8'(i))] <= bus.mem_wdata[8*i +: 8];
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [256];
    bit          lock_held;
    int          m_wait, m_lock;
    bit          e_rv [2];
    bit          e_err [2];
    logic [31:0] e_rd [2];

    function automatic logic [31:0] ref_rd(input logic [31:0] a, input logic [1:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < nbytes(w); i++) r[8*i +: 8] = ref_mem[8'(a[7:0] + 8'(i))];
        return r;
    endfunction

    always @(negedge clk) begin
        bit          rq [2];
        bit          we [2];
        logic [1:0]  wd [2];
        logic [31:0] ad [2];
        logic [31:0] dt [2];
        int          win;
        bit          bad;

        if (clr) for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        if (!reset_n) begin
            chk("rst_gnt0", bus.gnt0, 0);
            chk("rst_gnt1", bus.gnt1, 0);
            chk("rst_mem_we", bus.mem_we, 0);
            chk("rst_rvalid0", bus.rvalid0, 0);
            chk("rst_rvalid1", bus.rvalid1, 0);
            chk("rst_rdata0", bus.rdata0, 0);
            chk("rst_rdata1", bus.rdata1, 0);
            chk("rst_err0", bus.err0, 0);
            chk("rst_err1", bus.err1, 0);
            lock_held = 1'b0;
            m_wait = 0;
            m_lock = 0;
            e_rv[0] = 1'b0; e_rv[1] = 1'b0;
        end else begin
            rq[0] = bus.req0; we[0] = bus.we0; wd[0] = bus.width0; ad[0] = bus.addr0; dt[0] = bus.wdata0;
            rq[1] = bus.req1; we[1] = bus.we1; wd[1] = bus.width1; ad[1] = bus.addr1; dt[1] = bus.wdata1;

            chk("m_rvalid0", bus.rvalid0, e_rv[0]);
            chk("m_rvalid1", bus.rvalid1, e_rv[1]);
            if (e_rv[0]) begin
                chk("m_rdata0", bus.rdata0, e_rd[0]);
                chk("m_err0", bus.err0, e_err[0]);
            end
            if (e_rv[1]) begin
                chk("m_rdata1", bus.rdata1, e_rd[1]);
                chk("m_err1", bus.err1, e_err[1]);
            end

            // arbitration rules in priority order
            if (lock_held && rq[1])             win = (rq[0] && m_lock == MAX_LOCK) ? 0 : 1;
            else if (rq[1] && m_wait == MAX_WAIT) win = 1;
            else if (rq[0])                     win = 0;
            else if (rq[1])                     win = 1;
            else                                win = -1;

            chk("m_gnt0", bus.gnt0, win == 0);
            chk("m_gnt1", bus.gnt1, win == 1);

            e_rv[0] = 1'b0; e_rv[1] = 1'b0;
            if (win < 0) begin
                chk("m_mem_we", bus.mem_we, 0);
                chk("m_mem_width", bus.mem_width, 0);
                chk("m_mem_addr", bus.mem_addr, 0);
                chk("m_mem_wdata", bus.mem_wdata, 0);
            end else begin
                bad = misal(wd[win], ad[win]);
                chk("m_mem_we", bus.mem_we, we[win] && !bad);
                chk("m_mem_width", bus.mem_width, wd[win]);
                chk("m_mem_addr", bus.mem_addr, ad[win]);
                chk("m_mem_wdata", bus.mem_wdata, dt[win]);
                e_rv[win]  = 1'b1;
                e_err[win] = bad;
                e_rd[win]  = (!we[win] && !bad) ? ref_rd(ad[win], wd[win]) : 32'h0;
                if (we[win] && !bad)
                    for (int i = 0; i < nbytes(wd[win]); i++)
                        ref_mem[8'(ad[win][7:0] + 8'(i))] = dt[win][8*i +: 8];
            end

            if (win == 0)      lock_held = lock_held && rq[1] && bus.lock1;
            else if (win == 1) lock_held = bus.lock1;
            else               lock_held = 1'b0;

            if (!rq[1] || win == 1) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;

            if (win == 0 || !bus.lock1) m_lock = 0;
            else if (win == 1 && m_lock < MAX_LOCK) m_lock++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 0; bus.we0 = 0; bus.width0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.width1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
        bus.lock1 = 0;
    endtask

    initial begin
        logic g0, g1;
        idle_inputs();
        repeat (3) cyc();
        clr = 1'b0;
        reset_n = 1'b1;

        // port 0 alone: word store then load of 0x10
        bus.req0 = 1; bus.we0 = 1; bus.width0 = 2'b00; bus.addr0 = 32'h10; bus.wdata0 = 32'hDEADBEEF;
        @(negedge clk);
        chk("p0_store_gnt0", bus.gnt0, 1);
        chk("p0_store_mem_we", bus.mem_we, 1);
        cyc();
        bus.we0 = 0;
        @(negedge clk);
        chk("p0_load_gnt0", bus.gnt0, 1);
        chk("p0_store_rvalid0", bus.rvalid0, 1);
        cyc();
        bus.req0 = 0;
        @(negedge clk);
        chk("p0_load_rvalid0", bus.rvalid0, 1);
        chk("p0_load_rdata0", bus.rdata0, 32'hDEADBEEF);
        cyc();

        // starvation guard
        bus.req0 = 1; bus.we0 = 0; bus.width0 = 0; bus.addr0 = 32'h40;
        bus.req1 = 1; bus.we1 = 0; bus.width1 = 0; bus.addr1 = 32'h44;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("starve_gnt0_c%0d", c), bus.gnt0, c < 4);
            chk($sformatf("starve_gnt1_c%0d", c), bus.gnt1, c == 4);
            cyc();
        end
        @(negedge clk);
        chk("starve_wait_cleared", bus.gnt0, 1);
        cyc();
        bus.req0 = 0; bus.req1 = 0;
        cyc();

        // burst lock: 8 port-1 grants, one port-0 slot, then port 1 again
        bus.lock1 = 1; bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h30;
        for (int c = 0; c < 10; c++) begin
            if (c == 1) begin bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h34; end
            @(negedge clk);
            chk($sformatf("lock_gnt1_c%0d", c), bus.gnt1, c != 8);
            chk($sformatf("lock_gnt0_c%0d", c), bus.gnt0, c == 8);
            cyc();
        end
        bus.lock1 = 0; bus.req1 = 0;
        @(negedge clk);
        chk("lock_release_gnt0", bus.gnt0, 1);
        cyc();
        bus.req0 = 0;
        cyc();

        // mixed widths
        bus.req1 = 1; bus.we1 = 1; bus.width1 = 2'b01; bus.addr1 = 32'h21; bus.wdata1 = 32'hAB;
        @(negedge clk);
        chk("mix_byte_gnt1", bus.gnt1, 1);
        cyc();
        bus.req1 = 0;
        bus.req0 = 1; bus.we0 = 1; bus.width0 = 2'b10; bus.addr0 = 32'h22; bus.wdata0 = 32'h1234;
        @(negedge clk);
        chk("mix_half_gnt0", bus.gnt0, 1);
        cyc();
        bus.req0 = 0;
        bus.req1 = 1; bus.we1 = 0; bus.width1 = 2'b00; bus.addr1 = 32'h20;
        @(negedge clk);
        chk("mix_load_gnt1", bus.gnt1, 1);
        cyc();
        bus.req1 = 0;
        @(negedge clk);
        chk("mix_rvalid1", bus.rvalid1, 1);
        chk("mix_rdata1", bus.rdata1, 32'h1234AB00);
        cyc();

`ifdef DMEM_ARB_ALIGN_CHECK_EN
        bus.req0 = 1; bus.we0 = 1; bus.width0 = 2'b00; bus.addr0 = 32'h06; bus.wdata0 = 32'hCAFEF00D;
        @(negedge clk);
        chk("align_gnt0", bus.gnt0, 1);
        chk("align_mem_we", bus.mem_we, 0);
        cyc();
        bus.req0 = 0;
        @(negedge clk);
        chk("align_rvalid0", bus.rvalid0, 1);
        chk("align_err0", bus.err0, 1);
        chk("align_rdata0", bus.rdata0, 0);
        chk("align_mem04", {env_mem[7], env_mem[6], env_mem[5], env_mem[4]}, 0);
        cyc();
`endif

        // reset during a granted store
        bus.req0 = 1; bus.we0 = 1; bus.width0 = 2'b00; bus.addr0 = 32'h80; bus.wdata0 = 32'h55AA55AA;
        #1;
        chk("rstmid_pre_gnt0", bus.gnt0, 1);
        chk("rstmid_pre_mem_we", bus.mem_we, 1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_mem_we", bus.mem_we, 0);
        chk("rstmid_gnt0", bus.gnt0, 0);
        cyc();
        bus.req0 = 0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rstmid_no_write", {env_mem[8'h83], env_mem[8'h82], env_mem[8'h81], env_mem[8'h80]}, 0);
        chk("rstmid_rvalid0", bus.rvalid0, 0);
        chk("rstmid_rdata0", bus.rdata0, 0);
        chk("rstmid_mem_addr", bus.mem_addr, 0);
        cyc();
        bus.req0 = 1; bus.we0 = 0; bus.req1 = 1; bus.we1 = 0;
        @(negedge clk);
        chk("rstmid_idle_gnt0", bus.gnt0, 1);
        cyc();
        idle_inputs();
        cyc();

        // randomized traffic, requests held until granted
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                reset_n = 1'b0;
                @(negedge clk);
                cyc();
                reset_n = 1'b1;
            end
            @(negedge clk);
            g0 = bus.gnt0;
            g1 = bus.gnt1;
            cyc();
            if (!bus.req0 || g0) begin
                bus.req0   = ($urandom_range(0, 3) != 0);
                bus.we0    = 1'($urandom_range(0, 1));
                bus.width0 = 2'($urandom_range(0, 3));
                bus.addr0  = 32'($urandom_range(0, 255));
                bus.wdata0 = $urandom;
            end
            if (!bus.req1 || g1) begin
                bus.req1   = ($urandom_range(0, 2) != 0);
                bus.we1    = 1'($urandom_range(0, 1));
                bus.width1 = 2'($urandom_range(0, 3));
                bus.addr1  = 32'($urandom_range(0, 255));
                bus.wdata1 = $urandom;
            end
            if ($urandom_range(0, 9) == 0) bus.lock1 = ~bus.lock1;
        end
        idle_inputs();
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported `data_mem`. It shares the memory between the pipeline load/store path (port 0) and a debug/DMA port (port 1). It drives the memory's `WE`/`WidthSrc`/`A`/`WD` and returns registered read data and a valid strobe to the granted requester. Port 0 has fixed priority, with a starvation guard for port 1 and a bounded burst lock for port 1.

## Interface
- `MAX_WAIT`, default 4: consecutive denied cycles of `req1` after which port 1 is forced to win.
- `MAX_LOCK`, default 8: consecutive locked port-1 grants after which a pending port 0 gets one slot.
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `req0`, `req1`  in  1: access request; held until granted.
- `we0`, `we1`  in  1: 1 = store, 0 = load.
- `width0`, `width1`  in  2: access width; `00` = word, `10` = halfword, `01` = byte.
- `addr0`, `addr1`  in  32: byte address.
- `wdata0`, `wdata1`  in  32: store data, right-aligned.
- `lock1`  in  1: port 1 requests burst ownership.
- `gnt0`, `gnt1`  out  1: grant, combinational, same cycle as request.
- `rvalid0`, `rvalid1`  out  1: one-cycle response strobe.
- `rdata0`, `rdata1`  out  32: registered read data.
- `err0`, `err1`  out  1: misalignment error, qualified by `rvalid`.
- `mem_we`  out  1: to `data_mem` WE.
- `mem_width`  out  2: to `data_mem` WidthSrc.
- `mem_addr`  out  32: to `data_mem` A.
- `mem_wdata`  out  32: to `data_mem` WD.
- `mem_rdata`  in  32: from `data_mem` RD (combinational read).

## Operation
- **FSM states.** The state records who was granted in the previous cycle.
  - `IDLE`: no grant.
  - `OWN0`: port 0.
  - `OWN1`: port 1, unlocked.
  - `LOCK1`: port 1 with `lock1`=1 at grant.
- **Arbitration, evaluated in priority order:**
  1. In `LOCK1` with `req1`: port 1 wins. Exception: `req0`=1 and `lock_cnt`==`MAX_LOCK`, then port 0 wins once.
  2. `req1` and `wait_cnt`==`MAX_WAIT`: port 1 wins.
  3. `req0`: port 0 wins.
  4. `req1`: port 1 wins.
  5. Otherwise no grant.
- **Next state.** Winner port 0 goes to `OWN0`. Winner port 1 goes to `LOCK1` if `lock1`, else `OWN1`. No grant goes to `IDLE`. A port-0 slot taken during a lock returns to `LOCK1` if `req1`&&`lock1` is still asserted.
- **`wait_cnt`** (saturating at `MAX_WAIT`):
  - increments when `req1`=1 and `gnt1`=0;
  - clears on `gnt1` or when `req1`=0.
- **`lock_cnt`** (saturating at `MAX_LOCK`):
  - increments on each locked port-1 grant;
  - clears on a port-0 grant or when `lock1` drops.
- **Memory mux.** The winner's `we`/`width`/`addr`/`wdata` drive the `mem_*` outputs. With no grant: `mem_we`=0 and all other `mem_*` outputs are 0.
- **Response.** For every grant, load or store, the winner's `rvalid` pulses in the next cycle.
  - Loads: `rdata` = `mem_rdata` sampled at the grant edge.
  - Stores: `rdata` = 0.
- **Unsupported width.** Width `11` is treated as word.

## Timing
- **Grant latency.** A request granted in cycle N gets `gnt` in cycle N, combinational from `req` and the registered state/counters.
- **Store commit.** The store is committed by `data_mem` at the rising edge ending cycle N.
- **Load response.** `rvalid`/`rdata` are valid in cycle N+1 for exactly one cycle.
- **Back-to-back.** Grants on consecutive cycles are allowed. Full throughput is one access per cycle.
- **Reset values** (while `reset_n`=0):
  - state `IDLE`;
  - both counters 0;
  - `rvalid*`, `rdata*`, `err*` = 0;
  - `mem_we` forced 0 combinationally;
  - `gnt*` = 0.
- **Reset mid-access.** A store granted in the same cycle reset asserts is dropped (`mem_we`=0). A pending `rvalid` is cleared.
- **Simultaneous requests.** Both requests in `IDLE` with `wait_cnt`=0: port 0 wins, port 1 `wait_cnt`→1.

## Configuration
- **`DMEM_ARB_ALIGN_CHECK_EN` defined:**
  - a word access with `addr[1:0]`≠0, or a halfword access with `addr[0]`=1, is still granted;
  - `mem_we` is forced 0 for that access;
  - in N+1: `rvalid`=1, `err`=1, `rdata`=0.
- **Not defined:** accesses pass through unchanged; `err0`/`err1` are tied 0.

## Structure
- **Package `dmem_arb_pkg`:**
  - width constants `WIDTH_WORD`=2'b00, `WIDTH_HALF`=2'b10, `WIDTH_BYTE`=2'b01;
  - FSM enum `arb_state_t`;
  - a request struct: `we`, `width`, `addr`, `wdata`.
- **Sub-module `dmem_arb_align`:** combinational misalignment detector, instantiated per port only under the macro.

## Test plan
- **Port 0 alone:** `req0`, `we0`=1, word, `addr0`=0x10, `wdata0`=0xDEADBEEF; next cycle `req0` load 0x10 → `gnt0` both cycles, `rvalid0` in N+2 with `rdata0`=0xDEADBEEF.
- **Starvation:** `req0` and `req1` both held, `MAX_WAIT`=4 → port 0 granted cycles 0–3, port 1 granted cycle 4, `wait_cnt` back to 0.
- **Lock:** `lock1`=1, `req1` held, `req0` raised at lock grant 2 with `MAX_LOCK`=8 → port 1 gets 8 grants, port 0 one slot, port 1 resumes in `LOCK1`.
- **Mixed widths:**
  - byte store 0xAB to addr 0x21 via port 1;
  - halfword store 0x1234 to 0x22 via port 0;
  - word load 0x20 via port 1 → `rdata1`=0x1234AB00 (bytes 0x20–0x23 = 00, AB, 34, 12).
- **Alignment (macro on):** word store to 0x06 → `gnt0`=1, `mem_we`=0, next cycle `err0`=1, `rvalid0`=1; memory at 0x04 unchanged.
- **Reset mid-access:** assert `reset_n`=0 during a granted store → `mem_we`=0 immediately, no write, all outputs 0 and FSM `IDLE` after release.
